// File: rtl/lsu_axi_master_pkg.sv
// Shared encodings for the load/store unit bus master: core request
// codes, AXI response code, write size codes and controller states.
package lsu_axi_master_pkg;

    localparam logic [2:0] NO_MEM_READ     = 3'd0;
    localparam logic [2:0] MEM_READ_BYTE   = 3'd1;
    localparam logic [2:0] MEM_READ_HALF   = 3'd2;
    localparam logic [2:0] MEM_READ_WORD   = 3'd3;
    localparam logic [2:0] MEM_READ_BYTE_U = 3'd4;
    localparam logic [2:0] MEM_READ_HALF_U = 3'd5;

    localparam logic [1:0] NO_MEM_WRITE    = 2'd0;
    localparam logic [1:0] MEM_WRITE_BYTE  = 2'd1;
    localparam logic [1:0] MEM_WRITE_HALF  = 2'd2;
    localparam logic [1:0] MEM_WRITE_WORD  = 2'd3;

    localparam logic [1:0] AXI_OKAY        = 2'b00;

    // wstrb carries a size code, not a byte-lane mask
    localparam logic [1:0] WSTRB_BYTE      = 2'b01;
    localparam logic [1:0] WSTRB_HALF      = 2'b10;
    localparam logic [1:0] WSTRB_WORD      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_RSP
    } lsu_state_e;

    // Codes 6/7 are undefined and treated as "no read"
    function automatic logic is_read_req(input logic [2:0] rd);
        return (rd != NO_MEM_READ) && (rd <= MEM_READ_HALF_U);
    endfunction

    function automatic logic is_read_misaligned(input logic [2:0] rd, input logic [1:0] off);
        logic mis;
        case (rd)
            MEM_READ_HALF, MEM_READ_HALF_U: mis = off[0];
            MEM_READ_WORD:                  mis = (off != 2'b00);
            default:                        mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_write_misaligned(input logic [1:0] wr, input logic [1:0] off);
        logic mis;
        case (wr)
            MEM_WRITE_HALF: mis = off[0];
            MEM_WRITE_WORD: mis = (off != 2'b00);
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] wstrb_code(input logic [1:0] wr);
        logic [1:0] code;
        case (wr)
            MEM_WRITE_BYTE: code = WSTRB_BYTE;
            MEM_WRITE_HALF: code = WSTRB_HALF;
            MEM_WRITE_WORD: code = WSTRB_WORD;
            default:        code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lsu_axi_master_load_align.sv
// Load data alignment: picks the addressed byte/half out of a bus word,
// shifts it down and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_axi_master_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  mem_read_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension according to the load type
    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (mem_read_i)
            MEM_READ_BYTE:   result_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_READ_HALF:   result_o = {{16{half_sel[15]}}, half_sel};
            MEM_READ_WORD:   result_o = word_i;
            MEM_READ_BYTE_U: result_o = {24'd0, byte_sel};
            MEM_READ_HALF_U: result_o = {16'd0, half_sel};
            default:         result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit AXI-lite master: one core request at a time, turned
// into an AR/R or AW/W/B exchange, with a single registered response.
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic              awvalid_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wstrb_q;
    logic              wvalid_q;
    logic              bready_q;
    logic [2:0]        read_q;
    logic [1:0]        off_q;

    logic              rd_req;
    logic              wr_req;
    logic              rd_mis;
    logic              wr_mis;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W-1:0] load_word;

    // Request decode and per-channel completion in the WR state
    always_comb begin
        rd_req  = is_read_req(mem_read);
        wr_req  = (mem_write != NO_MEM_WRITE);
        rd_mis  = is_read_misaligned(mem_read, mem_addr[1:0]);
        wr_mis  = is_write_misaligned(mem_write, mem_addr[1:0]);
        // A channel counts as done once its valid has dropped or it handshakes now
        aw_done = !awvalid_q || awready;
        w_done  = !wvalid_q  || wready;
    end

    lsu_load_align u_align (
        .word_i     (rdata),
        .off_i      (off_q),
        .mem_read_i (read_q),
        .result_o   (load_word)
    );

    // Controller FSM with all bus/core outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            read_q      <= NO_MEM_READ;
            off_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        read_q      <= mem_read;
                        off_q       <= mem_addr[1:0];
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (rd_req) begin
                            if (rd_mis) begin
                                rsp_err_q   <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RSP;
                            end else begin
                                araddr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
                                arvalid_q <= 1'b1;
                                state_q   <= ST_AR;
                            end
                        end else if (wr_req) begin
                            if (wr_mis) begin
                                rsp_err_q   <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RSP;
                            end else begin
                                awaddr_q  <= mem_addr;
                                wdata_q   <= mem_wdata;
                                wstrb_q   <= wstrb_code(mem_write);
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= ST_WR;
                            end
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RSP;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= load_word;
                        rsp_err_q   <= (rresp != AXI_OKAY);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_WR: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= (bresp != AXI_OKAY);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed requests against a scripted AXI-lite
// slave; expected responses are queued and checked by a response monitor.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [1:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   ar_cycles = 0;
    int   aw_cycles = 0;
    int   aw_hs     = 0;
    int   w_hs      = 0;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Response monitor: pops one expected entry per accepted response
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    end

    // Bus activity counters
    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid)            ar_cycles++;
            if (awvalid)            aw_cycles++;
            if (awvalid && awready) aw_hs++;
            if (wvalid && wready)   w_hs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        for (int n = 0; n < 20 && !req_ready; n++) tick();
        check("req_ready_at_issue", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        mem_read  = 3'd0;
        mem_write = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && !req_ready; n++) tick();
        check("return_to_idle", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic read_slave(input logic [31:0] exp_araddr, input int ar_wait, input int r_wait,
                              input logic [31:0] data, input logic [1:0] resp);
        for (int n = 0; n < 20 && !arvalid; n++) tick();
        check("arvalid", {63'd0, arvalid}, 64'd1);
        check("araddr", {32'd0, araddr}, {32'd0, exp_araddr});
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            check("arvalid_hold", {63'd0, arvalid}, 64'd1);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rready", {63'd0, rready}, 64'd1);
        check("arvalid_drop", {63'd0, arvalid}, 64'd0);
        for (int i = 0; i < r_wait; i++) tick();
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rdata  = 32'd0;
        rresp  = 2'd0;
        check("rsp_valid_after_r", {63'd0, rsp_valid}, 64'd1);
        wait_idle();
    endtask

    task automatic write_slave(input logic [31:0] exp_awaddr, input logic [31:0] exp_wdata, input logic [1:0] exp_wstrb,
                               input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
        int  a0;
        int  w0;
        bit  aw_ok;
        bit  w_ok;
        a0    = aw_hs;
        w0    = w_hs;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        for (int n = 0; n < 20 && !(awvalid && wvalid); n++) tick();
        check("aw_w_valid_together", {62'd0, awvalid, wvalid}, 64'd3);
        check("awaddr", {32'd0, awaddr}, {32'd0, exp_awaddr});
        check("wdata", {32'd0, wdata}, {32'd0, exp_wdata});
        check("wstrb", {62'd0, wstrb}, {62'd0, exp_wstrb});
        for (int c = 0; c < 20 && !(aw_ok && w_ok); c++) begin
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            tick();
            if (c == aw_dly) aw_ok = 1'b1;
            if (c == w_dly)  w_ok  = 1'b1;
            awready = 1'b0;
            wready  = 1'b0;
            if (w_ok && !aw_ok) begin
                check("wvalid_dropped", {63'd0, wvalid}, 64'd0);
                check("awvalid_held", {63'd0, awvalid}, 64'd1);
            end
        end
        check("aw_handshakes", 64'(aw_hs - a0), 64'd1);
        check("w_handshakes", 64'(w_hs - w0), 64'd1);
        check("aw_w_valid_low", {62'd0, awvalid, wvalid}, 64'd0);
        check("bready", {63'd0, bready}, 64'd1);
        for (int i = 0; i < b_dly; i++) begin
            check("rsp_before_b", {63'd0, rsp_valid}, 64'd0);
            tick();
        end
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        bresp  = 2'd0;
        check("rsp_valid_after_b", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    initial begin : stim
        int a0;
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_read  = 3'd0;
        mem_write = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        rsp_ready = 1'b1;
        arready   = 1'b0;
        rdata     = 32'd0;
        rresp     = 2'd0;
        rvalid    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'd0;
        bvalid    = 1'b0;
        repeat (3) tick();
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_valids", {58'd0, rsp_valid, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        check("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("reset_addrs", {araddr, awaddr}, 64'd0);
        check("reset_wdata_wstrb", {30'd0, wdata, wstrb}, 64'd0);
        rst = 1'b0;
        tick();

        // lb, sign-extended top byte
        push(32'hFFFF_FF80, 1'b0);
        issue(3'd1, 2'd0, 32'h8000_0003, 32'd0);
        read_slave(32'h8000_0000, 0, 0, 32'h80FF_1234, 2'b00);

        // lhu, upper half zero-extended, with AR and R waits
        push(32'h0000_80FF, 1'b0);
        issue(3'd5, 2'd0, 32'h8000_0002, 32'd0);
        read_slave(32'h8000_0000, 2, 3, 32'h80FF_1234, 2'b00);

        // lh upper half sign-extended
        push(32'hFFFF_80FF, 1'b0);
        issue(3'd2, 2'd0, 32'h8000_0006, 32'd0);
        read_slave(32'h8000_0004, 0, 1, 32'h80FF_1234, 2'b00);

        // lb low byte, positive
        push(32'h0000_0034, 1'b0);
        issue(3'd1, 2'd0, 32'h8000_0100, 32'd0);
        read_slave(32'h8000_0100, 1, 0, 32'h80FF_1234, 2'b00);

        // lw aligned
        push(32'h80FF_1234, 1'b0);
        issue(3'd3, 2'd0, 32'h8000_0104, 32'd0);
        read_slave(32'h8000_0104, 0, 0, 32'h80FF_1234, 2'b00);

        // lbu with SLVERR read response
        push(32'h0000_00FF, 1'b1);
        issue(3'd4, 2'd0, 32'h8000_000A, 32'd0);
        read_slave(32'h8000_0008, 0, 0, 32'h80FF_1234, 2'b10);

        // sw, awready two cycles after wready
        push(32'h0000_0000, 1'b0);
        issue(3'd0, 2'd3, 32'h8000_0010, 32'hDEAD_BEEF);
        write_slave(32'h8000_0010, 32'hDEAD_BEEF, 2'b11, 2, 0, 2, 2'b00);
        wait_idle();

        // sh, both channels complete on the same edge
        push(32'h0000_0000, 1'b0);
        issue(3'd0, 2'd2, 32'h8000_0012, 32'h0000_BEEF);
        write_slave(32'h8000_0012, 32'h0000_BEEF, 2'b10, 0, 0, 0, 2'b00);
        wait_idle();

        // misaligned lw: immediate error, no AR
        push(32'h0000_0000, 1'b1);
        a0 = ar_cycles;
        issue(3'd3, 2'd0, 32'h8000_0002, 32'd0);
        check("mis_lw_latency", {63'd0, rsp_valid}, 64'd1);
        wait_idle();
        check("mis_lw_no_ar", 64'(ar_cycles - a0), 64'd0);

        // misaligned sh: immediate error, no AW
        push(32'h0000_0000, 1'b1);
        a0 = aw_cycles;
        issue(3'd0, 2'd2, 32'h8000_0013, 32'h1234_5678);
        check("mis_sh_latency", {63'd0, rsp_valid}, 64'd1);
        wait_idle();
        check("mis_sh_no_aw", 64'(aw_cycles - a0), 64'd0);

        // no-op request
        push(32'h0000_0000, 1'b0);
        issue(3'd0, 2'd0, 32'h8000_0040, 32'd0);
        check("noop_latency", {63'd0, rsp_valid}, 64'd1);
        wait_idle();

        // read and write together: read wins, write dropped
        push(32'h0000_0012, 1'b0);
        a0 = aw_cycles;
        issue(3'd4, 2'd3, 32'h8000_0001, 32'hFFFF_FFFF);
        read_slave(32'h8000_0000, 0, 0, 32'h80FF_1234, 2'b00);
        check("prio_no_aw", 64'(aw_cycles - a0), 64'd0);

        // sb with SLVERR, response held while core stalls
        rsp_ready = 1'b0;
        push(32'h0000_0000, 1'b1);
        issue(3'd0, 2'd1, 32'h8000_0021, 32'h1234_56A5);
        write_slave(32'h8000_0021, 32'h1234_56A5, 2'b01, 0, 1, 1, 2'b10);
        for (int i = 0; i < 3; i++) begin
            check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
            check("hold_rsp_err", {63'd0, rsp_err}, 64'd1);
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_idle();

        // reset while waiting in R abandons the read
        issue(3'd3, 2'd0, 32'h8000_0004, 32'd0);
        for (int n = 0; n < 20 && !arvalid; n++) tick();
        check("rst_case_arvalid", {63'd0, arvalid}, 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rst_case_in_r", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rready", {63'd0, rready}, 64'd0);
        check("rst_mid_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mid_valids", {60'd0, arvalid, awvalid, wvalid, rsp_valid}, 64'd0);

        push(32'hCAFE_F00D, 1'b0);
        issue(3'd3, 2'd0, 32'h8000_0008, 32'd0);
        read_slave(32'h8000_0008, 1, 2, 32'hCAFE_F00D, 2'b00);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Load/store unit bus master. Sits between the execute stage's memory request interface and the main-memory AXI-lite slave.
- Converts one core load/store request into AR/R or AW/W/B transactions.
- Aligns and extends read data, and returns a single response to the core.
- One outstanding request at a time. No pipelining.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed at 32; no other values supported).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  high in IDLE only
- mem_read  in  3  0 none, 1 byte, 2 half, 3 word, 4 byte_u, 5 half_u
- mem_write  in  2  0 none, 1 byte, 2 half, 3 word
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, low-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data (0 for stores)
- rsp_err  out  1  misaligned access or non-OKAY resp
- araddr  out  32  read address, word-aligned (addr & ~3)
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  read data word
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address, unmodified byte address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data, low-aligned, unshifted
- wstrb  out  2  01 byte, 10 half, 11 word
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- Reset: state IDLE; all valid/ready outputs low except req_ready, which is 1 in IDLE.
  - rsp_rdata, rsp_err, araddr, awaddr, wdata, wstrb reset to 0.
  - Reset mid-transaction abandons the transaction; all valids are low the cycle after the reset edge.
- States: IDLE, AR, R, WR, B, RSP.
- IDLE, on req_valid (handshake with req_ready):
  - Latch mem_read, mem_write, mem_addr, mem_wdata.
  - Read takes priority if both mem_read and mem_write are non-zero; the write is dropped.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Go to RSP with rsp_err=1 and no bus access.
  - Both mem_read and mem_write zero: go to RSP, err=0, rdata=0.
  - Otherwise go to AR for a read, WR for a write.
- AR: arvalid=1, araddr stable. On arready go to R.
- R: rready=1. On rvalid:
  - Select the byte/half at addr[1:0] and shift it down.
  - Sign-extend for byte/half; zero-extend for byte_u/half_u.
  - rsp_err = (rresp != OKAY). Go to RSP.
- WR: awvalid and wvalid asserted together on entry.
  - Each channel drops independently after its own handshake (track aw_done, w_done).
  - Go to B once both are done, including when both complete in the same cycle.
  - wstrb is a size code, not a byte mask: byte=01, half=10, word=11.
- B: bready=1. On bvalid, rsp_err = (bresp != OKAY), rsp_rdata=0. Go to RSP.
- RSP: rsp_valid=1; data/err held stable until rsp_ready, then go to IDLE.
  - req_ready stays low in RSP; there is no same-cycle back-to-back accept.
- Latency to rsp_valid:
  - Bus-free cases: 1 cycle after accept.
  - Read: 1 cycle to arvalid, plus slave AR wait, plus slave R latency, plus 1 cycle.
- Valid signals never drop before their handshake.
- Addresses and data on any channel stay stable while its valid is high.

Decomposition:
- Shared package/header holds:
  - mem_read and mem_write encodings (NO_MEM_READ, MEM_READ_BYTE..., NO_MEM_WRITE, MEM_WRITE_BYTE...).
  - OKAY response code.
  - wstrb size codes.
  - State constants.
- One natural sub-module: lsu_load_align. It is combinational: word, addr[1:0] and mem_read in; extended 32-bit result out.

Test Plan:
- lb at 0x80000003, slave rdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80, err=0; araddr=0x80000000.
- lhu at 0x80000002, rdata=0x80FF1234 -> rsp_rdata=0x000080FF.
- sw 0xDEADBEEF at 0x80000010, slave delays awready 2 cycles after wready -> awaddr=0x80000010, wstrb=11, a single W handshake; rsp_valid only after bvalid; rsp_rdata=0.
- lw at 0x80000002 -> rsp_valid 1 cycle after accept, err=1, arvalid never asserted.
- sb with bresp=SLVERR (2'b10) -> err=1; rsp_valid held 3 cycles while rsp_ready=0, values stable.
- Reset during R with rvalid low -> next cycle: IDLE, rready=0, req_ready=1; a subsequent lw completes normally.
